flame_ctrl: RTL and testbench

Sequencer that drives the flame sprite renderer's position and sprite-select inputs. On a bomb explosion it latches the bomb's grid cell and converts it to pixel coordinates. It then plays a grow-then-shrink animation across the 5 flame sprites, advancing only on frame boundaries so the renderer never sees a mid-frame change. It sits between the game logic (bomb timers) and the flame renderer/pixel mixer.

---
 rtl/bomberman_pkg.sv | 19 +
 rtl/cell2pix.sv | 22 ++
 rtl/flame_ctrl.sv | 144 ++++++++++++++
 tb/tb_flame_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Constants and types shared by the flame sequencer, the sprite renderers and the map logic.
// The grid is 16x16 cells of TILE pixels, offset by ORIGIN_X/ORIGIN_Y on screen.
package bomberman_pkg;

  localparam int TILE        = 32;
  localparam int ORIGIN_X    = 64;
  localparam int ORIGIN_Y    = 32;
  localparam int PARK        = 1000;
  localparam int NUM_SPRITES = 5;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  // Grow-then-shrink mapping: step 0..2N-2 -> sprite 0..N-1..0
  function automatic logic [2:0] sprite_of(input logic [3:0] step);
    if (step < 4'(NUM_SPRITES)) return 3'(step);
    return 3'(4'(2 * (NUM_SPRITES - 1)) - step);
  endfunction

endpackage

// File: rtl/cell2pix.sv
// Combinational grid-cell to top-left pixel conversion, shared with the bomb/player renderers.
// Sums are formed in 11 bits; the elaboration checks guarantee the result fits in 10.
module cell2pix
  import bomberman_pkg::*;
(
  input  logic [3:0] cell_x,
  input  logic [3:0] cell_y,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
);

  if (ORIGIN_X + 15 * TILE + TILE > 1023) begin : g_bad_origin_x
    $error("cell2pix: ORIGIN_X + 16*TILE exceeds 10-bit screen range");
  end
  if (ORIGIN_Y + 15 * TILE + TILE > 1023) begin : g_bad_origin_y
    $error("cell2pix: ORIGIN_Y + 16*TILE exceeds 10-bit screen range");
  end

  assign pix_x = 10'(11'(ORIGIN_X) + 11'(cell_x) * 11'(TILE));
  assign pix_y = 10'(11'(ORIGIN_Y) + 11'(cell_y) * 11'(TILE));

endmodule

// File: rtl/flame_ctrl.sv
// Flame animation sequencer: latches the exploding bomb's cell, then steps the renderer
// through sprites 0..4..0, changing outputs only on the cycle after a frame_tick.
module flame_ctrl
  import bomberman_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       explode,
  input  logic [3:0] cell_x,
  input  logic [3:0] cell_y,
  output logic [9:0] flame_centerX,
  output logic [9:0] flame_centerY,
  output logic [2:0] sprite_num,
  output logic       flame_active,
  output logic       busy,
  output logic       flame_done
);

  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 15) begin : g_bad_fps
    $error("flame_ctrl: FRAMES_PER_STEP must be 1..15");
  end

  localparam logic [3:0] HOLD_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] STEP_LAST = 4'(2 * NUM_SPRITES - 2);
  localparam logic [9:0] PARK_POS  = 10'(PARK);

  state_t     state_reg, state_next;
  logic [3:0] cell_x_reg, cell_x_next;
  logic [3:0] cell_y_reg, cell_y_next;
  logic [3:0] step_reg, step_next;
  logic [3:0] hold_reg, hold_next;
  logic [9:0] cx_reg, cx_next;
  logic [9:0] cy_reg, cy_next;
  logic [2:0] sprite_reg, sprite_next;
  logic       active_reg, active_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic [9:0] pix_x, pix_y;

  cell2pix u_cell2pix (
    .cell_x (cell_x_reg),
    .cell_y (cell_y_reg),
    .pix_x  (pix_x),
    .pix_y  (pix_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cell_x_reg <= '0;
      cell_y_reg <= '0;
      step_reg   <= '0;
      hold_reg   <= '0;
      cx_reg     <= PARK_POS;
      cy_reg     <= PARK_POS;
      sprite_reg <= '0;
      active_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cell_x_reg <= cell_x_next;
      cell_y_reg <= cell_y_next;
      step_reg   <= step_next;
      hold_reg   <= hold_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      sprite_reg <= sprite_next;
      active_reg <= active_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cell_x_next = cell_x_reg;
    cell_y_next = cell_y_reg;
    step_next   = step_reg;
    hold_next   = hold_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    sprite_next = sprite_reg;
    active_next = active_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A tick coinciding with explode is not used; ARMED waits for the next one
        if (explode) begin
          cell_x_next = cell_x;
          cell_y_next = cell_y;
          state_next  = ARMED;
          busy_next   = 1'b1;
        end
      end
      ARMED: begin
        if (frame_tick) begin
          state_next  = ACTIVE;
          step_next   = '0;
          hold_next   = '0;
          cx_next     = pix_x;
          cy_next     = pix_y;
          sprite_next = '0;
          active_next = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_tick) begin
          if (hold_reg != HOLD_LAST) begin
            hold_next = hold_reg + 4'd1;
          end else if (step_reg != STEP_LAST) begin
            hold_next   = '0;
            step_next   = step_reg + 4'd1;
            sprite_next = sprite_of(step_reg + 4'd1);
          end else begin
            state_next  = IDLE;
            hold_next   = '0;
            step_next   = '0;
            cx_next     = PARK_POS;
            cy_next     = PARK_POS;
            sprite_next = '0;
            active_next = 1'b0;
            busy_next   = 1'b0;
            done_next   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign flame_centerX = cx_reg;
  assign flame_centerY = cy_reg;
  assign sprite_num    = sprite_reg;
  assign flame_active  = active_reg;
  assign busy          = busy_reg;
  assign flame_done    = done_reg;

endmodule

// File: tb/tb_flame_ctrl.sv
// Bench for flame_ctrl: directed scenarios plus randomized ticks/explodes, checked every cycle
// against a model that counts frames since activation and looks up the sprite in a table.
module tb_flame_ctrl;

  localparam int FPS = 4;
  localparam int LIFE = 9 * FPS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       explode = 1'b0;
  logic [3:0] cell_x = '0;
  logic [3:0] cell_y = '0;
  logic [9:0] flame_centerX, flame_centerY;
  logic [2:0] sprite_num;
  logic       flame_active, busy, flame_done;

  flame_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .explode       (explode),
    .cell_x        (cell_x),
    .cell_y        (cell_y),
    .flame_centerX (flame_centerX),
    .flame_centerY (flame_centerY),
    .sprite_num    (sprite_num),
    .flame_active  (flame_active),
    .busy          (busy),
    .flame_done    (flame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: busy/armed/active flags, latched cell, ticks seen since activation
  int seq [9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
  bit m_busy, m_armed, m_active, m_done;
  int m_x, m_y, m_ticks;

  task automatic model_reset();
    m_busy = 0; m_armed = 0; m_active = 0; m_done = 0;
    m_x = 0; m_y = 0; m_ticks = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("centerX", flame_centerX, m_active ? 64 + m_x * 32 : 1000);
    check("centerY", flame_centerY, m_active ? 32 + m_y * 32 : 1000);
    check("sprite", sprite_num, m_active ? seq[m_ticks / FPS] : 0);
    check("active", flame_active, m_active);
    check("busy", busy, m_busy);
    check("done", flame_done, m_done);
  endtask

  task automatic step_cycle(input bit ex, input int x, input int y, input bit tk);
    explode = ex; cell_x = 4'(x); cell_y = 4'(y); frame_tick = tk;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (ex) begin
          m_busy = 1; m_armed = 1; m_x = x; m_y = y;
          $display("t=%0t explode accepted cell (%0d,%0d)", $time, x, y);
        end
      end else if (m_armed) begin
        if (tk) begin
          m_armed = 0; m_active = 1; m_ticks = 0;
        end
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == LIFE) begin
          m_active = 0; m_busy = 0; m_done = 1;
          $display("t=%0t flame finished cell (%0d,%0d)", $time, m_x, m_y);
        end
      end
    end
    #1;
    check_all();
    explode = 0; frame_tick = 0;
  endtask

  // n frames of given period; tick on the last cycle of each, optional random explodes
  task automatic frames(input int n, input int period, input bit rand_ex);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < period; c++) begin
        bit ex;
        ex = rand_ex && ($urandom_range(0, 7) == 0);
        step_cycle(ex, $urandom_range(0, 15), $urandom_range(0, 15), c == period - 1);
      end
    end
  endtask

  initial begin
    model_reset();
    // Reset held with random inputs
    for (int i = 0; i < 6; i++)
      step_cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1));
    #2 reset_n = 1'b1;
    frames(10, 5, 0);

    // Basic flame at (3,2), 800-cycle frames, with a dropped explode mid-flame
    step_cycle(1, 3, 2, 0);
    frames(1, 800, 0);
    check("basic_cx", flame_centerX, 160);
    check("basic_cy", flame_centerY, 96);
    frames(10, 800, 0);
    step_cycle(1, 7, 7, 0);
    frames(25, 800, 0);
    check("pre_end_sprite", sprite_num, 0);
    // Final tick with a simultaneous explode: explode must be ignored
    step_cycle(1, 5, 5, 1);
    check("end_done", flame_done, 1);
    check("end_busy", busy, 0);
    // First IDLE cycle accepts a request
    step_cycle(1, 15, 15, 0);
    check("rearm_busy", busy, 1);
    frames(1, 6, 0);
    check("max_cx", flame_centerX, 544);
    check("max_cy", flame_centerY, 512);
    frames(LIFE + 2, 6, 0);

    // Mid-run asynchronous reset at step 4
    step_cycle(1, 1, 1, 0);
    frames(1, 5, 0);
    frames(16, 5, 0);
    check("mid_sprite", sprite_num, 4);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_cx", flame_centerX, 1000);
    step_cycle(0, 0, 0, 1);
    step_cycle(0, 0, 0, 0);
    #2 reset_n = 1'b1;
    step_cycle(1, 2, 4, 0);
    frames(LIFE + 3, 5, 0);

    // Randomized ticks and explodes
    for (int i = 0; i < 300; i++) frames(1, $urandom_range(2, 8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
